// File: rtl/rtc_slew.sv
// Time-of-day counter with a programmable period and a delayed, bounded frequency slew.
// Optional capture of the current time on snap_trig when RTC_SLEW_SNAPSHOT_EN is defined.
module rtc_slew #(
    parameter int FRAC_W     = 8,
    parameter int PER_FRAC_W = 32,
    parameter int SEC_W      = 48,
    parameter int PPS_W      = 4,
    parameter logic [8+PER_FRAC_W-1:0] PERIOD_RST = (8+PER_FRAC_W)'(8) << PER_FRAC_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         time_ld,
    input  logic [30+FRAC_W-1:0]         time_ns_in,
    input  logic [SEC_W-1:0]             time_sec_in,
    input  logic                         period_ld,
    input  logic [8+PER_FRAC_W-1:0]      period_in,
    input  logic                         adj_ld,
    input  logic [31:0]                  adj_delay,
    input  logic [31:0]                  adj_cycles,
    input  logic signed [8+PER_FRAC_W-1:0] adj_step,
    output logic                         adj_busy,
    output logic                         adj_done,
    output logic [30+FRAC_W-1:0]         time_ns,
    output logic [SEC_W-1:0]             time_sec,
    output logic [31:0]                  time_ptp_ns,
    output logic [SEC_W-1:0]             time_ptp_sec,
    output logic                         time_pps,
    input  logic                         snap_trig,
    output logic                         snap_valid,
    output logic [30+FRAC_W-1:0]         snap_ns,
    output logic [SEC_W-1:0]             snap_sec
);
    localparam int ACC_W  = 30 + PER_FRAC_W;
    localparam int STEP_W = 8 + PER_FRAC_W;
    localparam int TNS_W  = 30 + FRAC_W;
    localparam logic [ACC_W:0] ONE_SEC = {31'd1000000000, {PER_FRAC_W{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SLEW, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [31:0]              cnt_q, cnt_d;
    logic [31:0]              cycles_q, cycles_d;
    logic signed [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0]        period_q, period_d;
    logic [ACC_W-1:0]         acc_q, acc_d;
    logic [SEC_W-1:0]         sec_q, sec_d;
    logic                     roll_q, roll_d;
    logic [7:0]               pps_cnt_q, pps_cnt_d;

    logic signed [STEP_W+1:0] step_ext;
    logic signed [STEP_W+1:0] inc_s;
    logic [STEP_W:0]          inc;
    logic [ACC_W:0]           sum;
    logic [ACC_W:0]           sum_wrap;
    logic                     roll;

    // Signed period+step; a negative result freezes time rather than running it backwards.
    always_comb begin
        step_ext = (state_q == S_SLEW) ? $signed({{2{step_q[STEP_W-1]}}, step_q}) : '0;
        inc_s    = $signed({2'b00, period_q}) + step_ext;
        inc      = inc_s[STEP_W+1] ? '0 : inc_s[STEP_W:0];
        sum      = {1'b0, acc_q} + {{(ACC_W-STEP_W){1'b0}}, inc};
        roll     = (sum >= ONE_SEC);
        sum_wrap = sum - ONE_SEC;
    end

    always_comb begin
        period_d  = period_ld ? period_in : period_q;
        acc_d     = roll ? sum_wrap[ACC_W-1:0] : sum[ACC_W-1:0];
        sec_d     = roll ? sec_q + 1'b1 : sec_q;
        roll_d    = roll;
        if (time_ld) begin
            acc_d  = ACC_W'(time_ns_in) << (PER_FRAC_W - FRAC_W);
            sec_d  = time_sec_in;
            roll_d = 1'b0;
        end
        // roll_q delays the pulse by one cycle so it follows the visible seconds change.
        if (roll_q)
            pps_cnt_d = 8'(PPS_W);
        else if (pps_cnt_q != 8'd0)
            pps_cnt_d = pps_cnt_q - 8'd1;
        else
            pps_cnt_d = 8'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cycles_q  <= '0;
            step_q    <= '0;
            period_q  <= PERIOD_RST;
            acc_q     <= '0;
            sec_q     <= '0;
            roll_q    <= 1'b0;
            pps_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cycles_q  <= cycles_d;
            step_q    <= step_d;
            period_q  <= period_d;
            acc_q     <= acc_d;
            sec_q     <= sec_d;
            roll_q    <= roll_d;
            pps_cnt_q <= pps_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        step_d   = step_q;
        if (adj_ld) begin
            state_d  = S_WAIT;
            cnt_d    = adj_delay;
            cycles_d = adj_cycles;
            step_d   = adj_step;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (cnt_q == 32'd0) begin
                        state_d = (cycles_q == 32'd0) ? S_DONE : S_SLEW;
                        cnt_d   = cycles_q;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                S_SLEW: begin
                    if (cnt_q <= 32'd1) begin
                        state_d = S_DONE;
                        cnt_d   = 32'd0;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A restart landing on the DONE cycle supersedes the completion pulse.
    always_comb begin
        adj_busy = (state_q == S_WAIT) || (state_q == S_SLEW);
        adj_done = (state_q == S_DONE) && !adj_ld;
    end

    assign time_ns      = acc_q[ACC_W-1 -: TNS_W];
    assign time_sec     = sec_q;
    assign time_ptp_ns  = {2'b00, acc_q[ACC_W-1 -: 30]};
    assign time_ptp_sec = sec_q;
    assign time_pps     = (pps_cnt_q != 8'd0);

`ifdef RTC_SLEW_SNAPSHOT_EN
    logic             snap_valid_q;
    logic [TNS_W-1:0] snap_ns_q;
    logic [SEC_W-1:0] snap_sec_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_valid_q <= 1'b0;
            snap_ns_q    <= '0;
            snap_sec_q   <= '0;
        end else begin
            snap_valid_q <= snap_trig;
            if (snap_trig) begin
                snap_ns_q  <= time_ns;
                snap_sec_q <= time_sec;
            end
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_ns    = snap_ns_q;
    assign snap_sec   = snap_sec_q;
`else
    logic snap_unused;
    assign snap_unused = snap_trig;
    assign snap_valid  = 1'b0;
    assign snap_ns     = '0;
    assign snap_sec    = '0;
`endif

endmodule

// File: tb/tb_rtc_slew.sv
// Directed bench for rtc_slew: free run, ToD load/rollover/wrap, period change,
// slew timing, negative-step clamp with restart, reset mid-slew and snapshot.
module tb_rtc_slew;
    logic                clk = 1'b0;
    logic                rst;
    logic                time_ld;
    logic [37:0]         time_ns_in;
    logic [47:0]         time_sec_in;
    logic                period_ld;
    logic [39:0]         period_in;
    logic                adj_ld;
    logic [31:0]         adj_delay;
    logic [31:0]         adj_cycles;
    logic signed [39:0]  adj_step;
    logic                adj_busy;
    logic                adj_done;
    logic [37:0]         time_ns;
    logic [47:0]         time_sec;
    logic [31:0]         time_ptp_ns;
    logic [47:0]         time_ptp_sec;
    logic                time_pps;
    logic                snap_trig;
    logic                snap_valid;
    logic [37:0]         snap_ns;
    logic [47:0]         snap_sec;

    int checks   = 0;
    int failures = 0;

    localparam logic [39:0] P8    = 40'd8 << 32;
    localparam logic [39:0] P12   = 40'd12 << 32;
    localparam logic [39:0] P8_5  = (40'd8 << 32) | (40'd1 << 31);
    localparam logic [39:0] STEP1 = 40'd1 << 32;
    localparam logic [39:0] STEPM9 = -(40'd9 << 32);

    rtc_slew dut (
        .clk         (clk),
        .rst         (rst),
        .time_ld     (time_ld),
        .time_ns_in  (time_ns_in),
        .time_sec_in (time_sec_in),
        .period_ld   (period_ld),
        .period_in   (period_in),
        .adj_ld      (adj_ld),
        .adj_delay   (adj_delay),
        .adj_cycles  (adj_cycles),
        .adj_step    (adj_step),
        .adj_busy    (adj_busy),
        .adj_done    (adj_done),
        .time_ns     (time_ns),
        .time_sec    (time_sec),
        .time_ptp_ns (time_ptp_ns),
        .time_ptp_sec(time_ptp_sec),
        .time_pps    (time_pps),
        .snap_trig   (snap_trig),
        .snap_valid  (snap_valid),
        .snap_ns     (snap_ns),
        .snap_sec    (snap_sec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    function automatic logic [37:0] ns_fx(input logic [29:0] n);
        return {n, 8'd0};
    endfunction

    task automatic load_time(input logic [29:0] n, input logic [47:0] s);
        time_ld     = 1'b1;
        time_ns_in  = ns_fx(n);
        time_sec_in = s;
    endtask

    int busy_cnt;
    int done_cnt;
    int done_at;

    initial begin
        rst = 1'b1; time_ld = 0; time_ns_in = '0; time_sec_in = '0;
        period_ld = 0; period_in = '0; adj_ld = 0; adj_delay = '0;
        adj_cycles = '0; adj_step = '0; snap_trig = 0;

        repeat (2) @(negedge clk);
        check("rst_ns",    64'(time_ns), 64'd0);
        check("rst_sec",   64'(time_sec), 64'd0);
        check("rst_busy",  64'(adj_busy), 64'd0);
        check("rst_done",  64'(adj_done), 64'd0);
        check("rst_pps",   64'(time_pps), 64'd0);
        check("rst_snapv", 64'(snap_valid), 64'd0);
        rst = 1'b0;

        // Free run at reset period: 125 x 8 ns
        repeat (125) @(negedge clk);
        check("free_ptp",  64'(time_ptp_ns), 64'd1000);
        check("free_ns",   64'(time_ns), 64'(ns_fx(30'd1000)));
        check("free_sec",  64'(time_sec), 64'd0);
        check("free_busy", 64'(adj_busy), 64'd0);

        // Load just below the second boundary, then roll over and stretch the PPS
        load_time(30'd999999992, 48'd5);
        @(negedge clk); time_ld = 0;
        check("ld_ns",  64'(time_ptp_ns), 64'd999999992);
        check("ld_sec", 64'(time_sec), 64'd5);
        check("ld_pps", 64'(time_pps), 64'd0);
        @(negedge clk);
        check("roll_ns",  64'(time_ptp_ns), 64'd0);
        check("roll_sec", 64'(time_ptp_sec), 64'd6);
        check("roll_pps_early", 64'(time_pps), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("pps_hi%0d", i), 64'(time_pps), 64'd1);
        end
        @(negedge clk);
        check("pps_lo", 64'(time_pps), 64'd0);

        // Seconds wrap
        load_time(30'd999999992, 48'hFFFF_FFFF_FFFF);
        @(negedge clk); time_ld = 0;
        check("wrap_pre", 64'(time_sec), 64'hFFFF_FFFF_FFFF);
        @(negedge clk);
        check("wrap_sec", 64'(time_sec), 64'd0);
        check("wrap_ns",  64'(time_ptp_ns), 64'd0);

        // Out-of-range load rolls over on the first increment
        load_time(30'd1000000004, 48'd7);
        @(negedge clk); time_ld = 0;
        check("ovr_ld",  64'(time_ptp_ns), 64'd1000000004);
        @(negedge clk);
        check("ovr_ns",  64'(time_ptp_ns), 64'd12);
        check("ovr_sec", 64'(time_sec), 64'd8);
        repeat (6) @(negedge clk);

        // time_ld beats a pending rollover and never fires PPS
        load_time(30'd999999992, 48'd3);
        @(negedge clk);
        load_time(30'd100, 48'd1);
        @(negedge clk); time_ld = 0;
        check("prio_ns",  64'(time_ptp_ns), 64'd100);
        check("prio_sec", 64'(time_sec), 64'd1);
        repeat (3) @(negedge clk);
        check("prio_pps", 64'(time_pps), 64'd0);

        // 8.5 ns period, 4 cycles from 0
        load_time(30'd0, 48'd0);
        period_ld = 1; period_in = P8_5;
        @(negedge clk); time_ld = 0; period_ld = 0;
        check("p85_t0", 64'(time_ns), 64'd0);
        @(negedge clk);
        check("p85_t1", 64'(time_ns), 64'd2176);
        repeat (3) @(negedge clk);
        check("p85_t4", 64'(time_ns), 64'(ns_fx(30'd34)));
        period_ld = 1; period_in = P8;
        @(negedge clk); period_ld = 0;

        // Slew +1 ns for 10 cycles after a 3-cycle delay
        load_time(30'd0, 48'd0);
        adj_ld = 1; adj_delay = 32'd3; adj_cycles = 32'd10; adj_step = STEP1;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        @(negedge clk); time_ld = 0; adj_ld = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            busy_cnt += int'(adj_busy);
            if (adj_done) begin done_cnt++; done_at = k; end
        end
        check("slew_busy",    64'(busy_cnt), 64'd14);
        check("slew_done",    64'(done_cnt), 64'd1);
        check("slew_done_at", 64'(done_at), 64'd14);
        check("slew_ns",      64'(time_ptp_ns), 64'd170);

        // -9 ns step on 8 ns period freezes time; restart mid-SLEW
        load_time(30'd0, 48'd0);
        adj_ld = 1; adj_delay = 32'd0; adj_cycles = 32'd5; adj_step = STEPM9;
        done_cnt = 0; done_at = -1;
        @(negedge clk); time_ld = 0; adj_ld = 0;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) @(negedge clk);
            if (adj_done) begin done_cnt++; done_at = k; end
            if (k == 2)  check("clamp_frz",  64'(time_ptp_ns), 64'd8);
            if (k == 3)  check("clamp_busy", 64'(adj_busy), 64'd1);
            if (k == 9)  check("clamp_frz2", 64'(time_ptp_ns), 64'd16);
            if (k == 14) check("clamp_end",  64'(time_ptp_ns), 64'd48);
            adj_ld = (k == 3);
        end
        check("abort_done",    64'(done_cnt), 64'd1);
        check("abort_done_at", 64'(done_at), 64'd10);

        // Reset mid-slew restores PERIOD_RST and drops the request
        load_time(30'd0, 48'd0);
        period_ld = 1; period_in = P12;
        adj_ld = 1; adj_delay = 32'd0; adj_cycles = 32'd3; adj_step = STEP1;
        @(negedge clk); time_ld = 0; period_ld = 0; adj_ld = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_busy", 64'(adj_busy), 64'd0);
        check("mrst_ns",   64'(time_ns), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_first", 64'(time_ns), 64'(ns_fx(30'd8)));
        done_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            done_cnt += int'(adj_done);
        end
        check("mrst_nodone", 64'(done_cnt), 64'd0);
        check("mrst_ns6",    64'(time_ptp_ns), 64'd48);

        // Snapshot at 400 ns
        load_time(30'd0, 48'd2);
        @(negedge clk); time_ld = 0;
        repeat (50) @(negedge clk);
        check("snap_pre", 64'(time_ptp_ns), 64'd400);
        snap_trig = 1;
        @(negedge clk); snap_trig = 0;
`ifdef RTC_SLEW_SNAPSHOT_EN
        check("snap_valid", 64'(snap_valid), 64'd1);
        check("snap_ns",    64'(snap_ns), 64'(ns_fx(30'd400)));
        check("snap_sec",   64'(snap_sec), 64'd2);
        @(negedge clk);
        check("snap_pulse", 64'(snap_valid), 64'd0);
        check("snap_hold",  64'(snap_ns), 64'(ns_fx(30'd400)));
`else
        check("snap_valid", 64'(snap_valid), 64'd0);
        check("snap_ns",    64'(snap_ns), 64'd0);
        check("snap_sec",   64'(snap_sec), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rtc_slew.md
RTC_SLEW -- requirements
Module: rtc_slew

Interface
REQ-001 Parameter FRAC_W, default 8: ns-fraction bits on time_ns output.
REQ-002 Parameter PER_FRAC_W, default 32: ns-fraction bits of period, step and internal accumulator.
REQ-003 Parameter SEC_W, default 48: seconds counter width.
REQ-004 Parameter PPS_W, default 4: time_pps pulse length in clk cycles, 1..255.
REQ-005 Parameter PERIOD_RST, default 8 ns (8 in bits [PER_FRAC_W+7:PER_FRAC_W], fraction 0): period after reset.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 time_ld / time_ns_in [30+FRAC_W-1:0] / time_sec_in [SEC_W-1:0]  in  direct ToD load strobe and value.
REQ-009 period_ld / period_in [8+PER_FRAC_W-1:0]  in  unsigned nominal period load strobe and value.
REQ-010 adj_ld / adj_delay [31:0] / adj_cycles [31:0] / adj_step [8+PER_FRAC_W-1:0] signed  in  slew request.
REQ-011 adj_busy, adj_done  out  1  slew in progress; one-cycle completion pulse.
REQ-012 time_ns [30+FRAC_W-1:0], time_sec [SEC_W-1:0]  out  current time, ns with truncated fraction.
REQ-013 time_ptp_ns [31:0] = {2'b0, integer ns}; time_ptp_sec [SEC_W-1:0] = time_sec  out.
REQ-014 time_pps  out  1  stretched one-pulse-per-second.
REQ-015 snap_trig in 1; snap_valid out 1; snap_ns, snap_sec out (widths as time_ns, time_sec)  timestamp capture.

Function
REQ-016 Accumulator holds ns at 30+PER_FRAC_W bits; time_ns = accumulator truncated to FRAC_W fraction bits (no delta-sigma).
REQ-017 Each cycle without time_ld: inc = period + (state==SLEW ? adj_step : 0), signed; inc < 0 SHALL be clamped to 0.
REQ-018 If acc+inc >= 10^9 ns: acc <= acc+inc-10^9 ns, sec +1 same cycle; else acc <= acc+inc.
REQ-019 Seconds SHALL wrap 2^SEC_W-1 -> 0 without other effect.
REQ-020 time_ld: next cycle time_ns/time_sec equal loaded values exactly (fraction below FRAC_W zeroed); increment resumes the cycle after; time_ld has priority over increment and rollover.
REQ-021 time_ns_in >= 10^9 ns: loaded as-is, first increment SHALL roll over.
REQ-022 period_ld: new period used from the accumulation in the cycle after the strobe.
REQ-023 Slew FSM states IDLE, WAIT, SLEW, DONE.
REQ-024 IDLE --adj_ld--> WAIT, latch adj_delay/adj_cycles/adj_step, delay counter = adj_delay.
REQ-025 WAIT: decrement each cycle; at 0 -> SLEW with cycle counter = adj_cycles; adj_cycles==0 -> DONE directly.
REQ-026 SLEW: adj_step applied exactly adj_cycles cycles, then DONE.
REQ-027 DONE: adj_done=1 for that single cycle, -> IDLE.
REQ-028 adj_busy=1 in WAIT and SLEW.
REQ-029 adj_ld in WAIT/SLEW/DONE: abort, relatch, restart in WAIT; no adj_done for aborted request.
REQ-030 time_ld and period_ld SHALL NOT affect the FSM.
REQ-031 time_pps rises the cycle after a seconds increment, stays high PPS_W cycles; a new increment during the pulse restarts the count; time_ld never triggers it.

Reset
REQ-032 On rst: acc=0, time_sec=0, period=PERIOD_RST, FSM=IDLE, counters 0, adj_busy=0, adj_done=0, time_pps=0, snap_valid=0, snap_ns=0, snap_sec=0.
REQ-033 rst mid-slew abandons it with no adj_done; first post-reset cycle accumulates PERIOD_RST.

Configuration
REQ-034 Macro RTC_SLEW_SNAPSHOT_EN defined: snap_trig sampled each cycle; next cycle snap_valid=1 for one cycle, snap_ns/snap_sec = time_ns/time_sec present during trigger cycle; held until next trigger.
REQ-035 Macro undefined: ports present, snap_trig ignored, snap_valid/snap_ns/snap_sec constant 0, no snapshot registers.

Verification
REQ-036 Reset, 125 cycles at 8 ns -> time_ptp_ns=1000, time_sec=0, adj_busy=0.
REQ-037 time_ld ns=999999992, sec=5 -> next cycle 999999992/5; following cycle ns=0, sec=6; time_pps high 4 cycles, one cycle later.
REQ-038 period_in=8.5 ns, 4 cycles from 0 -> time_ns=34 ns, fraction 0.
REQ-039 adj_delay=3, adj_cycles=10, adj_step=+1 ns -> adj_busy 14 cycles; +10 ns vs nominal; adj_done one pulse.
REQ-040 adj_step=-9 ns, period 8 ns -> time frozen during SLEW (clamp); adj_ld mid-SLEW -> restart, one adj_done only.
REQ-041 RTC_SLEW_SNAPSHOT_EN: snap_trig when time_ptp_ns=400 -> snap_valid next cycle, snap_ns=400 ns; without macro snap_valid stays 0.
